// File: rtl/zone_pkg.sv
// Shared grid constants, derived-size helpers and channel indices for the zone tracker.
// Imported by the interface-facing top, the per-channel tracker and the bench.
package zone_pkg;

  localparam int unsigned IMG_WIDTH_DEF  = 640;
  localparam int unsigned IMG_HEIGHT_DEF = 480;
  localparam int unsigned NX_DEF         = 8;
  localparam int unsigned NY_DEF         = 6;

  localparam int unsigned CH_BLUE = 0;
  localparam int unsigned CH_RED  = 1;

  function automatic int unsigned calc_zbw(int unsigned zones);
    return (zones > 1) ? $clog2(zones) : 1;
  endfunction

  function automatic int unsigned calc_unit(int unsigned extent, int unsigned cells);
    return extent / cells;
  endfunction

  localparam int unsigned ZBW_DEF = calc_zbw(NX_DEF * NY_DEF);

  typedef logic [ZBW_DEF-1:0] zone_t;

  // Outcome of one frame as seen by the stability/loss filter.
  typedef enum logic [1:0] {
    FrMiss,
    FrSame,
    FrNew
  } frame_res_e;

endpackage

// File: rtl/zone_tracker_multi_if.sv
// Pixel stream from the colour detectors in, per-channel zone results out.
// master = detector/frame-timing side, slave = zone tracker.
interface zone_tracker_multi_if #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned ZBW   = 6,
  parameter int unsigned CNT_W = 16
) ();
  logic                 frame_start;
  logic                 frame_end;
  logic                 pixel_valid;
  logic [9:0]           x_pixel;
  logic [9:0]           y_pixel;
  logic [NCH-1:0]       hit;
  logic                 result_strobe;
  logic [NCH*ZBW-1:0]   zone;
  logic [NCH*CNT_W-1:0] zone_count;
  logic [NCH-1:0]       zone_valid;

  modport master (
    output frame_start, frame_end, pixel_valid, x_pixel, y_pixel, hit,
    input  result_strobe, zone, zone_count, zone_valid
  );

  modport slave (
    input  frame_start, frame_end, pixel_valid, x_pixel, y_pixel, hit,
    output result_strobe, zone, zone_count, zone_valid
  );
endinterface

// File: rtl/zone_chan_tracker.sv
// One colour channel: per-zone hit counters with a running max, then an end-of-frame
// filter that applies the minimum count, stability and loss rules to the published zone.
module zone_chan_tracker
  import zone_pkg::*;
#(
  parameter int unsigned ZONES         = 48,
  parameter int unsigned ZBW           = 6,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned MIN_COUNT     = 64,
  parameter int unsigned STABLE_FRAMES = 2,
  parameter int unsigned LOST_FRAMES   = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             frame_start_i,
  input  logic             frame_end_i,
  input  logic             pix_ok_i,
  input  logic             hit_i,
  input  logic [ZBW-1:0]   zid_i,
  output logic [ZBW-1:0]   zone_o,
  output logic [CNT_W-1:0] zone_count_o,
  output logic             zone_valid_o
);

  localparam int unsigned MissW = $clog2(LOST_FRAMES + 1);
  localparam int unsigned CandW = $clog2(STABLE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q [ZONES];
  logic [CNT_W-1:0] max_cnt_q, cnt_base, cnt_new, max_base;
  logic [ZBW-1:0]   max_zone_q, max_zone_base;
  logic             acc, take;

  // A frame_start in the same cycle makes the pixel see an already-cleared frame.
  always_comb begin
    acc           = pix_ok_i && hit_i && !frame_end_i;
    cnt_base      = frame_start_i ? '0 : cnt_q[zid_i];
    cnt_new       = (cnt_base == CntMax) ? cnt_base : cnt_base + 1'b1;
    max_base      = frame_start_i ? '0 : max_cnt_q;
    max_zone_base = frame_start_i ? '0 : max_zone_q;
    take          = acc && ((cnt_new > max_base) || (zid_i == max_zone_base));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int z = 0; z < ZONES; z++) cnt_q[z] <= '0;
      max_cnt_q  <= '0;
      max_zone_q <= '0;
    end else begin
      if (frame_start_i) begin
        for (int z = 0; z < ZONES; z++) cnt_q[z] <= '0;
      end
      if (acc) cnt_q[zid_i] <= cnt_new;
      if (take) begin
        max_cnt_q  <= cnt_new;
        max_zone_q <= zid_i;
      end else if (frame_start_i) begin
        max_cnt_q  <= '0;
        max_zone_q <= '0;
      end
    end
  end

  logic [ZBW-1:0]   zone_q, cand_q;
  logic [CNT_W-1:0] zone_count_q;
  logic             valid_q;
  logic [CandW-1:0] cand_cnt_q, cand_next;
  logic [MissW-1:0] miss_q;
  frame_res_e       res;

  always_comb begin
    if (32'(max_cnt_q) < MIN_COUNT)  res = FrMiss;
    else if (max_zone_q == zone_q)   res = FrSame;
    else                             res = FrNew;
    cand_next = ((cand_cnt_q != '0) && (cand_q == max_zone_q)) ? cand_cnt_q + 1'b1
                                                              : CandW'(1);
  end

  // Frame_end always sees the pre-clear state, so a coincident frame_start is harmless here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      zone_q       <= '0;
      zone_count_q <= '0;
      valid_q      <= 1'b0;
      cand_q       <= '0;
      cand_cnt_q   <= '0;
      miss_q       <= '0;
    end else if (frame_end_i) begin
      zone_count_q <= max_cnt_q;
      unique case (res)
        FrMiss: begin
          cand_cnt_q <= '0;
          if (32'(miss_q) < LOST_FRAMES) miss_q <= miss_q + 1'b1;
          if (32'(miss_q) + 1 >= LOST_FRAMES) valid_q <= 1'b0;
        end
        FrSame: begin
          miss_q     <= '0;
          valid_q    <= 1'b1;
          cand_cnt_q <= '0;
        end
        FrNew: begin
          if (32'(cand_next) >= STABLE_FRAMES) begin
            zone_q     <= max_zone_q;
            valid_q    <= 1'b1;
            miss_q     <= '0;
            cand_cnt_q <= '0;
          end else begin
            cand_q     <= max_zone_q;
            cand_cnt_q <= cand_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign zone_o       = zone_q;
  assign zone_count_o = zone_count_q;
  assign zone_valid_o = valid_q;

endmodule

// File: rtl/zone_tracker_multi.sv
// Multi-channel zone tracker: shared pixel-to-zone mapping feeding NCH channel trackers,
// with a common one-cycle result strobe after each frame_end.
module zone_tracker_multi
  import zone_pkg::*;
#(
  parameter int unsigned IMG_WIDTH     = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT    = IMG_HEIGHT_DEF,
  parameter int unsigned NX            = NX_DEF,
  parameter int unsigned NY            = NY_DEF,
  parameter int unsigned NCH           = 2,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned MIN_COUNT     = 64,
  parameter int unsigned STABLE_FRAMES = 2,
  parameter int unsigned LOST_FRAMES   = 4
) (
  input logic                 clk,
  input logic                 reset_n,
  zone_tracker_multi_if.slave bus
);

  localparam int unsigned ZONES  = NX * NY;
  localparam int unsigned ZBW    = calc_zbw(ZONES);
  localparam int unsigned X_UNIT = calc_unit(IMG_WIDTH, NX);
  localparam int unsigned Y_UNIT = calc_unit(IMG_HEIGHT, NY);

  int unsigned    col, row;
  logic [ZBW-1:0] zid;
  logic           pix_ok;
  logic           strobe_q;

  always_comb begin
    col    = 32'(bus.x_pixel) / X_UNIT;
    row    = 32'(bus.y_pixel) / Y_UNIT;
    zid    = ZBW'(row * NX + col);
    pix_ok = bus.pixel_valid && (32'(bus.x_pixel) < IMG_WIDTH) &&
             (32'(bus.y_pixel) < IMG_HEIGHT);
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    zone_chan_tracker #(
      .ZONES        (ZONES),
      .ZBW          (ZBW),
      .CNT_W        (CNT_W),
      .MIN_COUNT    (MIN_COUNT),
      .STABLE_FRAMES(STABLE_FRAMES),
      .LOST_FRAMES  (LOST_FRAMES)
    ) u_chan (
      .clk_i        (clk),
      .rst_ni       (reset_n),
      .frame_start_i(bus.frame_start),
      .frame_end_i  (bus.frame_end),
      .pix_ok_i     (pix_ok),
      .hit_i        (bus.hit[c]),
      .zid_i        (zid),
      .zone_o       (bus.zone[c*ZBW +: ZBW]),
      .zone_count_o (bus.zone_count[c*CNT_W +: CNT_W]),
      .zone_valid_o (bus.zone_valid[c])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) strobe_q <= 1'b0;
    else          strobe_q <= bus.frame_end;
  end

  assign bus.result_strobe = strobe_q;

endmodule

// File: tb/tb_zone_tracker_multi.sv
// Bench for zone_tracker_multi: two parameterisations share one stimulus stream and are
// checked every cycle against a frame-level model, plus hand-computed pinned results.
module tb_zone_tracker_multi;
  import zone_pkg::*;

  localparam int NZ = 48;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       fs, fe, pv;
  logic [9:0] xp, yp;
  logic [1:0] hitv;

  zone_tracker_multi_if #(.NCH(2), .ZBW(6), .CNT_W(16)) ifa ();
  zone_tracker_multi_if #(.NCH(2), .ZBW(6), .CNT_W(4))  ifb ();

  assign ifa.frame_start = fs;
  assign ifa.frame_end   = fe;
  assign ifa.pixel_valid = pv;
  assign ifa.x_pixel     = xp;
  assign ifa.y_pixel     = yp;
  assign ifa.hit         = hitv;
  assign ifb.frame_start = fs;
  assign ifb.frame_end   = fe;
  assign ifb.pixel_valid = pv;
  assign ifb.x_pixel     = xp;
  assign ifb.y_pixel     = yp;
  assign ifb.hit         = hitv;

  zone_tracker_multi #(.CNT_W(16)) u_dut_a (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (ifa)
  );

  zone_tracker_multi #(
    .CNT_W        (4),
    .MIN_COUNT    (4),
    .STABLE_FRAMES(1),
    .LOST_FRAMES  (2)
  ) u_dut_b (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (ifb)
  );

  // Model parameters per instance: saturation value, min count, stability, loss.
  int p_max[2]  = '{65535, 15};
  int p_min[2]  = '{64, 4};
  int p_stab[2] = '{2, 1};
  int p_lost[2] = '{4, 2};

  int m_cnt[2][2][NZ];
  int m_rt[2][2][NZ];
  int m_zone[2][2], m_count[2][2], m_valid[2][2];
  int m_cand[2][2], m_ccnt[2][2], m_miss[2][2];
  int seqn;
  int exp_strobe;

  typedef struct {
    int    inst;
    int    ch;
    int    zone;
    int    cnt;
    int    valid;
    string name;
  } lit_t;
  lit_t lit_q[$];
  int   lit_rd = 0;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;

  task automatic model_clear_frame();
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 2; c++)
        for (int z = 0; z < NZ; z++) begin
          m_cnt[i][c][z] = 0;
          m_rt[i][c][z]  = 1 << 30;
        end
  endtask

  task automatic model_reset();
    model_clear_frame();
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 2; c++) begin
        m_zone[i][c] = 0; m_count[i][c] = 0; m_valid[i][c] = 0;
        m_cand[i][c] = 0; m_ccnt[i][c]  = 0; m_miss[i][c]  = 0;
      end
    exp_strobe = 0;
  endtask

  // Winner = highest count; among equals, the zone that got to that count earliest.
  task automatic model_frame_end(input int i, input int c);
    int wz, wc, wt;
    wz = 0; wc = m_cnt[i][c][0]; wt = m_rt[i][c][0];
    for (int z = 1; z < NZ; z++) begin
      if (m_cnt[i][c][z] > wc || (m_cnt[i][c][z] == wc && wc > 0 && m_rt[i][c][z] < wt)) begin
        wz = z; wc = m_cnt[i][c][z]; wt = m_rt[i][c][z];
      end
    end
    m_count[i][c] = wc;
    if (wc < p_min[i]) begin
      m_ccnt[i][c] = 0;
      if (m_miss[i][c] < p_lost[i]) m_miss[i][c]++;
      if (m_miss[i][c] >= p_lost[i]) m_valid[i][c] = 0;
    end else if (wz == m_zone[i][c]) begin
      m_miss[i][c] = 0; m_valid[i][c] = 1; m_ccnt[i][c] = 0;
    end else begin
      if (m_ccnt[i][c] > 0 && m_cand[i][c] == wz) m_ccnt[i][c]++;
      else begin
        m_cand[i][c] = wz; m_ccnt[i][c] = 1;
      end
      if (m_ccnt[i][c] >= p_stab[i]) begin
        m_zone[i][c] = wz; m_valid[i][c] = 1; m_miss[i][c] = 0; m_ccnt[i][c] = 0;
      end
    end
  endtask

  task automatic model_edge();
    int z;
    exp_strobe = fe ? 1 : 0;
    if (fe) for (int i = 0; i < 2; i++) for (int c = 0; c < 2; c++) model_frame_end(i, c);
    if (fs) model_clear_frame();
    if (pv && !fe && xp < 640 && yp < 480) begin
      z = (int'(yp) / 80) * 8 + int'(xp) / 80;
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < 2; c++)
          if (hitv[c] && m_cnt[i][c][z] < p_max[i]) begin
            m_cnt[i][c][z]++;
            m_rt[i][c][z] = seqn;
          end
      seqn++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
  endtask

  function automatic int dut_zone(int i, int c);
    if (i == 0) return int'(ifa.zone[c*6 +: 6]);
    return int'(ifb.zone[c*6 +: 6]);
  endfunction

  function automatic int dut_cnt(int i, int c);
    if (i == 0) return int'(ifa.zone_count[c*16 +: 16]);
    return int'(ifb.zone_count[c*4 +: 4]);
  endfunction

  function automatic int dut_valid(int i, int c);
    if (i == 0) return int'(ifa.zone_valid[c]);
    return int'(ifb.zone_valid[c]);
  endfunction

  task automatic cmp(input string nm, input int i, input int c, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s inst%0d ch%0d @%0t: got %0d, expected %0d", nm, i, c, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    lit_t l;
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        cmp("strobe", i, 0,
            (i == 0) ? int'(ifa.result_strobe) : int'(ifb.result_strobe), exp_strobe);
        for (int c = 0; c < 2; c++) begin
          cmp("zone", i, c, dut_zone(i, c), m_zone[i][c]);
          cmp("zone_count", i, c, dut_cnt(i, c), m_count[i][c]);
          cmp("zone_valid", i, c, dut_valid(i, c), m_valid[i][c]);
        end
      end
      while (lit_rd < lit_q.size()) begin
        l = lit_q[lit_rd];
        cmp({l.name, "_zone"}, l.inst, l.ch, dut_zone(l.inst, l.ch), l.zone);
        cmp({l.name, "_count"}, l.inst, l.ch, dut_cnt(l.inst, l.ch), l.cnt);
        cmp({l.name, "_valid"}, l.inst, l.ch, dut_valid(l.inst, l.ch), l.valid);
        lit_rd++;
      end
    end
  end

  task automatic pin(input string nm, input int i, input int c, input int z, input int n,
                     input int v);
    lit_t l;
    l.name = nm; l.inst = i; l.ch = c; l.zone = z; l.cnt = n; l.valid = v;
    lit_q.push_back(l);
  endtask

  task automatic set_zone_pix(input int z, input int k);
    xp = 10'((z % 8) * 80 + (k % 80));
    yp = 10'((z / 8) * 80 + ((k / 80) % 80));
  endtask

  task automatic hits(input int z, input int n, input logic [1:0] m);
    for (int k = 0; k < n; k++) begin
      pv = 1'b1; hitv = m; set_zone_pix(z, k);
      tick();
    end
    pv = 1'b0; hitv = '0;
  endtask

  task automatic start_frame();
    fs = 1'b1; tick(); fs = 1'b0;
  endtask

  task automatic end_frame();
    fe = 1'b1; tick(); fe = 1'b0;
  endtask

  task automatic rand_pixel(input int hot0, input int hot1);
    int sel, z;
    pv   = ($urandom_range(99) < 85);
    hitv = 2'($urandom_range(1, 3));
    sel  = $urandom_range(99);
    if (sel < 92) begin
      z = (sel < 55) ? hot0 : (sel < 80) ? hot1 : $urandom_range(NZ - 1);
      set_zone_pix(z, $urandom_range(6399));
    end else if (sel < 96) begin
      xp = 10'($urandom_range(640, 1023)); yp = 10'($urandom_range(479));
    end else begin
      xp = 10'($urandom_range(1023)); yp = 10'($urandom_range(480, 1023));
    end
  endtask

  localparam logic [1:0] MB = 2'(1 << CH_BLUE);
  localparam logic [1:0] MR = 2'(1 << CH_RED);

  initial begin
    int hot0, hot1, r;
    reset_n = 1'b1; fs = 0; fe = 0; pv = 0; xp = '0; yp = '0; hitv = '0; seqn = 0;
    model_reset();
    #2 reset_n = 1'b0;
    chk_on = 1'b1;
    for (int i = 0; i < 2; i++) for (int c = 0; c < 2; c++) pin("reset", i, c, 0, 0, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // 100 hits in zone 13: B publishes at once, A needs a second frame
    start_frame(); hits(13, 100, MB); end_frame();
    pin("f1", 0, 0, 0, 100, 0); pin("f1", 1, 0, 13, 15, 1); pin("f1", 0, 1, 0, 0, 0);
    start_frame(); hits(13, 100, MB); end_frame();
    pin("f2", 0, 0, 13, 100, 1);

    // Loss: valid holds for three empty frames and drops on the fourth
    for (int f = 0; f < 4; f++) begin
      start_frame(); tick(); tick(); end_frame();
      if (f == 2) pin("lost3", 0, 0, 13, 0, 1);
      if (f == 3) pin("lost4", 0, 0, 13, 0, 0);
    end

    // 60 + 60 below threshold for A; saturated tie for B keeps zone 5
    start_frame(); hits(5, 60, MB); hits(9, 60, MB); end_frame();
    pin("sixty", 0, 0, 13, 60, 0); pin("sixty", 1, 0, 5, 15, 1);

    // Stability on A: zone 3 twice, then zone 20 twice
    start_frame(); hits(3, 70, MB); end_frame(); pin("s3a", 0, 0, 13, 70, 0);
    start_frame(); hits(3, 70, MB); end_frame(); pin("s3b", 0, 0, 3, 70, 1);
    start_frame(); hits(20, 70, MB); end_frame(); pin("s20a", 0, 0, 3, 70, 1);
    start_frame(); hits(20, 70, MB); end_frame(); pin("s20b", 0, 0, 20, 70, 1);

    // CNT_W=4 tie on red: first zone to reach 15 keeps it
    start_frame(); hits(7, 20, MR); hits(30, 16, MR); end_frame();
    pin("tie", 1, 1, 7, 15, 1); pin("tie", 0, 1, 0, 20, 0);

    // Pixel on frame_start counts, pixel on frame_end is dropped: exactly MIN_COUNT
    fs = 1'b1; pv = 1'b1; hitv = MB; set_zone_pix(20, 0); tick(); fs = 1'b0;
    hits(20, 63, MB);
    fe = 1'b1; pv = 1'b1; hitv = MB; set_zone_pix(20, 5); tick(); fe = 1'b0; pv = 1'b0;
    pin("edge64", 0, 0, 20, 64, 1);

    // Combined frame_end+frame_start, then a frame_end with no frame_start
    start_frame(); hits(20, 70, MB);
    fs = 1'b1; fe = 1'b1; tick(); fs = 1'b0; fe = 1'b0;
    pin("combo", 0, 0, 20, 70, 1);
    hits(20, 10, MB); end_frame();
    pin("nostart", 0, 0, 20, 10, 1);

    // Reset mid-frame, then a fresh frame behaves as from reset
    start_frame(); hits(13, 50, MB);
    reset_n = 1'b0; model_reset();
    for (int i = 0; i < 2; i++) for (int c = 0; c < 2; c++) pin("midrst", i, c, 0, 0, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    start_frame(); hits(13, 100, MB); end_frame();
    pin("after_rst", 0, 0, 0, 100, 0); pin("after_rst", 1, 0, 13, 15, 1);

    // Random frames against the model
    hot0 = $urandom_range(NZ - 1); hot1 = $urandom_range(NZ - 1);
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(99) >= 60) hot0 = $urandom_range(NZ - 1);
      hot1 = $urandom_range(NZ - 1);
      r = $urandom_range(99);
      if (r >= 8) begin
        fs = 1'b1; rand_pixel(hot0, hot1); tick(); fs = 1'b0;
      end
      for (int k = 0; k < $urandom_range(80, 300); k++) begin
        rand_pixel(hot0, hot1); tick();
      end
      fe = 1'b1; fs = ($urandom_range(99) < 5); rand_pixel(hot0, hot1);
      tick();
      fe = 1'b0; fs = 1'b0; pv = 1'b0;
      for (int g = 0; g < $urandom_range(3); g++) tick();
    end

    tick(); tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
